// File: rtl/soc_clk_div_pkg.sv
// soc_clk_div_pkg
// Shared types, default constants and helpers for the multi-channel clock
// divider bank (soc_clk_div_bank / soc_clk_div_chan).
//   cfg_req_t       : layout of a configuration request (channel, divisor, enable)
//                     at the default widths.
//   DefResetDiv/En  : per-channel values loaded at reset (50 MHz -> 1 MHz).
//   div_below_two() : true when a divisor must be clamped up to 2.
package soc_clk_div_pkg;

    localparam int DefNumChannels = 2;
    localparam int DefCntWidth    = 16;
    localparam int MaxCntWidth    = 32;
    localparam int MaxChanWidth   = 4;

    localparam logic [DefCntWidth-1:0] DefResetDiv = 16'd50;
    localparam logic                   DefResetEn  = 1'b1;

    typedef struct packed {
        logic [MaxChanWidth-1:0] chan;
        logic [DefCntWidth-1:0]  div;
        logic                    en;
    } cfg_req_t;

    // Effective divisor is max(div, 2): anything below 2 (0 or 1) is clamped.
    // Callers zero-extend their divisor to MaxCntWidth bits.
    function automatic logic div_below_two(input logic [MaxCntWidth-1:0] div);
        return (div[MaxCntWidth-1:1] == '0);
    endfunction

endpackage

// File: rtl/soc_clk_div_chan.sv
// soc_clk_div_chan
// One divider channel: period counter, staging register for divisor updates,
// registered divided clock and start-of-period tick.
// Ports:
//   soc_clk, rst_n : clock, asynchronous active-low reset
//   wr_i           : configuration transfer targeted at this channel
//   wr_div_i       : new divisor
//   wr_en_i        : new enable
//   pend_o         : an update is staged and waits for the period boundary
//   div_clk_o      : divided clock (registered)
//   tick_o         : one-cycle pulse coincident with the rising edge of div_clk_o
module soc_clk_div_chan
    import soc_clk_div_pkg::*;
#(
    parameter int                  CntWidth = DefCntWidth,
    parameter logic [CntWidth-1:0] ResetDiv = CntWidth'(50),
    parameter logic                ResetEn  = 1'b1
) (
    input  logic                soc_clk,
    input  logic                rst_n,
    input  logic                wr_i,
    input  logic [CntWidth-1:0] wr_div_i,
    input  logic                wr_en_i,
    output logic                pend_o,
    output logic                div_clk_o,
    output logic                tick_o
);

    logic [CntWidth-1:0] div_q, div_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] stg_div_q, stg_div_d;
    logic                en_q, en_d;
    logic                pend_q, pend_d;
    logic                clk_q, clk_d;
    logic                tick_q, tick_d;

    logic [CntWidth-1:0] deff;
    logic [CntWidth-1:0] hi;
    logic [CntWidth-1:0] last_cnt;
    logic                active;
    logic                at_boundary;

    always_comb begin
        deff        = div_below_two(MaxCntWidth'(div_q)) ? CntWidth'(2) : div_q;
        hi          = deff >> 1;
        last_cnt    = deff - CntWidth'(1);
        active      = en_q && (div_q != '0);
        at_boundary = (cnt_q == last_cnt);

        div_d     = div_q;
        en_d      = en_q;
        pend_d    = pend_q;
        stg_div_d = stg_div_q;
        cnt_d     = '0;
        clk_d     = 1'b0;
        tick_d    = 1'b0;

        if (active) begin
            cnt_d  = at_boundary ? '0 : cnt_q + CntWidth'(1);
            // Outputs are registered: high in the cycle after cnt_q is 0..hi-1.
            clk_d  = (cnt_q < hi);
            tick_d = (cnt_q == '0);
            // A staged update only lands once the running period has finished.
            if (pend_q && at_boundary) begin
                div_d  = stg_div_q;
                pend_d = 1'b0;
            end
        end

        // The port never presents a transfer while pend_q is set, so a write
        // here cannot collide with the staged-apply path above.
        if (wr_i) begin
            if (!active || !wr_en_i) begin
                // Idle channel or a disable: take effect at once, restart low.
                div_d  = wr_div_i;
                en_d   = wr_en_i;
                pend_d = 1'b0;
                cnt_d  = '0;
                clk_d  = 1'b0;
                tick_d = 1'b0;
            end else begin
                // Running channel: stage it. A staged request always has
                // enable set (disables take the path above), so only the
                // divisor needs holding. A write on the boundary cycle is
                // applied at the following boundary because apply looks at
                // pend_q, not pend_d.
                stg_div_d = wr_div_i;
                pend_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= ResetDiv;
            en_q      <= ResetEn;
            cnt_q     <= '0;
            stg_div_q <= '0;
            pend_q    <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            en_q      <= en_d;
            cnt_q     <= cnt_d;
            stg_div_q <= stg_div_d;
            pend_q    <= pend_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign pend_o    = pend_q;
    assign div_clk_o = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/soc_clk_div_bank.sv
// soc_clk_div_bank
// Bank of NumChannels run-time-programmable clock dividers / tick generators.
// A single valid/ready configuration port writes one channel per cycle.
// Ports:
//   soc_clk, rst_n : clock, asynchronous active-low reset
//   cfg_valid_i    : configuration request valid
//   cfg_ready_o    : request accepted this cycle when high together with valid
//   cfg_chan_i     : target channel index
//   cfg_div_i      : new divisor
//   cfg_en_i       : new enable
//   cfg_err_o      : one-cycle pulse after a request to a non-existent channel
//   div_clk_o      : divided clock per channel
//   tick_o         : start-of-period pulse per channel
module soc_clk_div_bank
    import soc_clk_div_pkg::*;
#(
    parameter int                               NumChannels = DefNumChannels,
    parameter int                               CntWidth    = DefCntWidth,
    parameter logic [NumChannels*CntWidth-1:0]  ResetDiv    = {NumChannels{DefResetDiv}},
    parameter logic [NumChannels-1:0]           ResetEn     = {NumChannels{DefResetEn}},
    localparam int                              ChanWidth   = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                   soc_clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [ChanWidth-1:0]   cfg_chan_i,
    input  logic [CntWidth-1:0]    cfg_div_i,
    input  logic                   cfg_en_i,
    output logic                   cfg_err_o,
    output logic [NumChannels-1:0] div_clk_o,
    output logic [NumChannels-1:0] tick_o
);

    logic [NumChannels-1:0] pend;
    logic [NumChannels-1:0] wr;
    logic                   chan_in_range;
    logic                   xfer;
    logic                   cfg_err_q, cfg_err_d;

    assign chan_in_range = ({1'b0, cfg_chan_i} < (ChanWidth+1)'(NumChannels));

    // Out-of-range indices match no channel and are therefore always ready,
    // so they are accepted and dropped rather than stalling the port.
    always_comb begin
        cfg_ready_o = 1'b1;
        for (int c = 0; c < NumChannels; c++) begin
            if (cfg_chan_i == ChanWidth'(c)) begin
                cfg_ready_o = ~pend[c];
            end
        end
    end

    assign xfer      = cfg_valid_i && cfg_ready_o;
    assign cfg_err_d = xfer && !chan_in_range;

    generate
        for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
            assign wr[gi] = xfer && (cfg_chan_i == ChanWidth'(gi));

            soc_clk_div_chan #(
                .CntWidth (CntWidth),
                .ResetDiv (ResetDiv[gi*CntWidth +: CntWidth]),
                .ResetEn  (ResetEn[gi])
            ) u_chan (
                .soc_clk   (soc_clk),
                .rst_n     (rst_n),
                .wr_i      (wr[gi]),
                .wr_div_i  (cfg_div_i),
                .wr_en_i   (cfg_en_i),
                .pend_o    (pend[gi]),
                .div_clk_o (div_clk_o[gi]),
                .tick_o    (tick_o[gi])
            );
        end
    endgenerate

    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_soc_clk_div_bank.sv
module tb_soc_clk_div_bank;

    // Three channels so that an out-of-range index (3) is representable on
    // the 2-bit channel field.
    localparam int NCH = 3;
    localparam int CW  = 16;

    logic           soc_clk = 1'b0;
    logic           rst_n   = 1'b1;
    logic           cfg_valid_i = 1'b0;
    logic           cfg_ready_o;
    logic [1:0]     cfg_chan_i = '0;
    logic [CW-1:0]  cfg_div_i  = '0;
    logic           cfg_en_i   = 1'b0;
    logic           cfg_err_o;
    logic [NCH-1:0] div_clk_o;
    logic [NCH-1:0] tick_o;

    soc_clk_div_bank #(
        .NumChannels (NCH),
        .CntWidth    (CW)
    ) dut (
        .soc_clk     (soc_clk),
        .rst_n       (rst_n),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_chan_i  (cfg_chan_i),
        .cfg_div_i   (cfg_div_i),
        .cfg_en_i    (cfg_en_i),
        .cfg_err_o   (cfg_err_o),
        .div_clk_o   (div_clk_o),
        .tick_o      (tick_o)
    );

    always #5 soc_clk = ~soc_clk;

    int cyc = 0;
    always @(posedge soc_clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Observed-event logs (filled by the monitor) and expectation queues
    // (filled by the tests when stimulus is applied).
    int tick_log0[$];
    int tick_log1[$];
    int high_log0[$];
    int high_log1[$];
    int err_log[$];
    int exp_tick_q[$];
    int exp_high_q[$];
    int run0 = 0, run1 = 0, hi_samp0 = 0;
    int anchor0 = 0, anchor1 = 0;

    always @(negedge soc_clk) begin
        if (tick_o[0]) tick_log0.push_back(cyc);
        if (tick_o[1]) tick_log1.push_back(cyc);
        if (div_clk_o[0]) begin
            run0++;
            hi_samp0++;
        end else if (run0 != 0) begin
            high_log0.push_back(run0);
            run0 = 0;
        end
        if (div_clk_o[1]) begin
            run1++;
        end else if (run1 != 0) begin
            high_log1.push_back(run1);
            run1 = 0;
        end
        if (cfg_err_o) err_log.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) @(posedge soc_clk);
        #1;
    endtask

    task automatic settle();
        @(negedge soc_clk);
        #1;
    endtask

    task automatic clear_logs();
        tick_log0.delete();
        tick_log1.delete();
        high_log0.delete();
        high_log1.delete();
        err_log.delete();
        exp_tick_q.delete();
        exp_high_q.delete();
        hi_samp0 = 0;
    endtask

    // Presents one request and holds it until accepted (bounded).
    task automatic cfg_write(input int ch, input int div, input bit en,
                             output int xfer, output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        @(posedge soc_clk);
        #1;
        cfg_chan_i  = 2'(ch);
        cfg_div_i   = CW'(div);
        cfg_en_i    = en;
        cfg_valid_i = 1'b1;
        #1;
        while (!cfg_ready_o) begin
            if (n >= 200) begin
                ok = 1'b0;
                break;
            end
            @(posedge soc_clk);
            #1;
            n++;
        end
        if (ok) begin
            @(posedge soc_clk);
            #1;
        end
        xfer = cyc;
        cfg_valid_i = 1'b0;
        $display("cfg ch=%0d div=%0d en=%0d accepted=%0d at cycle %0d", ch, div, en, ok, xfer);
    endtask

    task automatic test_reset();
        int r0, e, a;
        #2 rst_n = 1'b0;
        step(3);
        cfg_chan_i = 2'd1;
        #1;
        vectors++;
        if (div_clk_o !== '0 || tick_o !== '0 || cfg_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got clk=%b tick=%b err=%b want 0", div_clk_o, tick_o, cfg_err_o);
        end
        vectors++;
        if (cfg_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 1", cfg_ready_o);
        end
        rst_n = 1'b1;
        r0 = cyc;
        clear_logs();
        for (int k = 0; k < 10; k++) exp_tick_q.push_back(r0 + 1 + 50 * k);
        for (int k = 0; k < 3; k++) exp_high_q.push_back(25);
        step(500);
        settle();
        $display("reset release at cycle %0d: ch0 ticks=%0d", r0, tick_log0.size());
        vectors++;
        if (tick_log0.size() != 10) begin
            miscompares++;
            $display("FAIL reset_tick_count: got %0d want 10", tick_log0.size());
        end
        vectors++;
        if (tick_log1.size() == 0 || tick_log1[0] != r0 + 1) begin
            miscompares++;
            $display("FAIL reset_ch1_first_tick: got %0d want %0d",
                     (tick_log1.size() > 0) ? tick_log1[0] : -1, r0 + 1);
        end
        while (exp_tick_q.size() > 0) begin
            e = exp_tick_q.pop_front();
            a = -1;
            if (tick_log0.size() > 0) a = tick_log0.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL reset_ch0_tick: got %0d want %0d", a, e);
            end
        end
        while (exp_high_q.size() > 0) begin
            e = exp_high_q.pop_front();
            a = -1;
            if (high_log0.size() > 0) a = high_log0.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL reset_ch0_high: got %0d want %0d", a, e);
            end
        end
        anchor1 = r0 + 1;
    endtask

    task automatic test_div_update();
        int x, b, phase, e, a;
        bit ok;
        step(17);
        cfg_write(1, 7, 1'b1, x, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL upd_accept: got timeout want accepted");
        end
        // ch1 has run at 50 since reset with its first count-0 edge at anchor1.
        phase = (x - anchor1) % 50;
        b = (phase == 49) ? x + 50 : x + 49 - phase;
        clear_logs();
        for (int k = 0; k < 4; k++) exp_tick_q.push_back(b + 1 + 7 * k);
        for (int k = 0; k < 3; k++) exp_high_q.push_back(3);
        vectors++;
        if (cfg_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL upd_ready_pending: got %b want 0", cfg_ready_o);
        end
        cfg_chan_i = 2'd0;
        #1;
        vectors++;
        if (cfg_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL upd_ready_other: got %b want 1", cfg_ready_o);
        end
        cfg_chan_i = 2'd1;
        #1;
        step(b - 1 - cyc);
        vectors++;
        if (cfg_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL upd_ready_before_boundary: got %b want 0", cfg_ready_o);
        end
        step(1);
        vectors++;
        if (cfg_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL upd_ready_after_boundary: got %b want 1", cfg_ready_o);
        end
        high_log1.delete();
        step(30);
        settle();
        while (exp_tick_q.size() > 0) begin
            e = exp_tick_q.pop_front();
            a = -1;
            if (tick_log1.size() > 0) a = tick_log1.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL upd_ch1_tick: got %0d want %0d", a, e);
            end
        end
        while (exp_high_q.size() > 0) begin
            e = exp_high_q.pop_front();
            a = -1;
            if (high_log1.size() > 0) a = high_log1.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL upd_ch1_high: got %0d want %0d", a, e);
            end
        end
        anchor1 = b + 1;
    endtask

    task automatic test_disable_enable();
        int x, y, e, a;
        bit ok;
        cfg_write(0, 50, 1'b0, x, ok);
        vectors++;
        if (!ok || div_clk_o[0] !== 1'b0 || tick_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL dis_immediate: got ok=%0d clk=%b tick=%b want 1/0/0", ok, div_clk_o[0], tick_o[0]);
        end
        clear_logs();
        step(60);
        settle();
        vectors++;
        if (tick_log0.size() != 0 || hi_samp0 != 0) begin
            miscompares++;
            $display("FAIL dis_quiet: got ticks=%0d high=%0d want 0/0", tick_log0.size(), hi_samp0);
        end
        cfg_write(0, 2, 1'b1, y, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL en_accept: got timeout want accepted");
        end
        clear_logs();
        for (int k = 0; k < 5; k++) exp_tick_q.push_back(y + 1 + 2 * k);
        for (int k = 0; k < 4; k++) exp_high_q.push_back(1);
        step(12);
        settle();
        while (exp_tick_q.size() > 0) begin
            e = exp_tick_q.pop_front();
            a = -1;
            if (tick_log0.size() > 0) a = tick_log0.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL en_div2_tick: got %0d want %0d", a, e);
            end
        end
        while (exp_high_q.size() > 0) begin
            e = exp_high_q.pop_front();
            a = -1;
            if (high_log0.size() > 0) a = high_log0.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL en_div2_high: got %0d want %0d", a, e);
            end
        end
    endtask

    task automatic test_div_zero_one();
        int x, y, n, e, a;
        bit ok;
        cfg_write(0, 0, 1'b1, x, ok);
        vectors++;
        if (!ok || cfg_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL div0_staged: got ok=%0d ready=%b want 1/0", ok, cfg_ready_o);
        end
        n = 0;
        while (!cfg_ready_o && n < 10) begin
            step(1);
            n++;
        end
        vectors++;
        if (cfg_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL div0_apply: got ready=%b want 1 within 10 cycles", cfg_ready_o);
        end
        clear_logs();
        step(20);
        settle();
        vectors++;
        if (tick_log0.size() != 0 || hi_samp0 != 0) begin
            miscompares++;
            $display("FAIL div0_quiet: got ticks=%0d high=%0d want 0/0", tick_log0.size(), hi_samp0);
        end
        cfg_write(0, 1, 1'b1, y, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL div1_accept: got timeout want accepted");
        end
        clear_logs();
        for (int k = 0; k < 4; k++) exp_tick_q.push_back(y + 1 + 2 * k);
        for (int k = 0; k < 3; k++) exp_high_q.push_back(1);
        step(10);
        settle();
        while (exp_tick_q.size() > 0) begin
            e = exp_tick_q.pop_front();
            a = -1;
            if (tick_log0.size() > 0) a = tick_log0.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL div1_tick: got %0d want %0d", a, e);
            end
        end
        while (exp_high_q.size() > 0) begin
            e = exp_high_q.pop_front();
            a = -1;
            if (high_log0.size() > 0) a = high_log0.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL div1_high: got %0d want %0d", a, e);
            end
        end
        anchor0 = y + 1;
    endtask

    task automatic test_out_of_range();
        int x, e, a;
        step(3);
        cfg_chan_i  = 2'd3;
        cfg_div_i   = CW'(3);
        cfg_en_i    = 1'b0;
        cfg_valid_i = 1'b1;
        #1;
        vectors++;
        if (cfg_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_ready: got %b want 1", cfg_ready_o);
        end
        clear_logs();
        @(posedge soc_clk);
        #1;
        x = cyc;
        cfg_valid_i = 1'b0;
        cfg_chan_i  = 2'd0;
        $display("cfg ch=3 div=3 en=0 (out of range) at cycle %0d", x);
        exp_tick_q.push_back(x);
        step(25);
        settle();
        vectors++;
        if (err_log.size() != 1) begin
            miscompares++;
            $display("FAIL oor_err_count: got %0d want 1", err_log.size());
        end
        e = exp_tick_q.pop_front();
        a = -1;
        if (err_log.size() > 0) a = err_log.pop_front();
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL oor_err_cycle: got %0d want %0d", a, e);
        end
        vectors++;
        if (tick_log0.size() < 10 || tick_log1.size() < 3) begin
            miscompares++;
            $display("FAIL oor_channels_running: got ch0=%0d ch1=%0d want >=10/>=3",
                     tick_log0.size(), tick_log1.size());
        end
        foreach (tick_log0[i]) begin
            vectors++;
            if ((tick_log0[i] - anchor0) % 2 != 0) begin
                miscompares++;
                $display("FAIL oor_ch0_phase: got tick %0d want multiple of 2 from %0d", tick_log0[i], anchor0);
            end
        end
        foreach (tick_log1[i]) begin
            vectors++;
            if ((tick_log1[i] - anchor1) % 7 != 0) begin
                miscompares++;
                $display("FAIL oor_ch1_phase: got tick %0d want multiple of 7 from %0d", tick_log1[i], anchor1);
            end
        end
    endtask

    task automatic test_reset_midperiod();
        int x, r2, e, a;
        bit ok;
        // Line up the transfer with a high phase of ch0 (divide-by-2).
        if (((cyc + 2 - anchor0) % 2) != 0) step(1);
        cfg_write(1, 9, 1'b1, x, ok);
        vectors++;
        if (!ok || cfg_ready_o !== 1'b0 || div_clk_o[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pre: got ok=%0d ready=%b ch0clk=%b want 1/0/1", ok, cfg_ready_o, div_clk_o[0]);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (div_clk_o !== '0 || tick_o !== '0) begin
            miscompares++;
            $display("FAIL rstmid_async: got clk=%b tick=%b want 0/0", div_clk_o, tick_o);
        end
        vectors++;
        if (cfg_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pending_cleared: got ready=%b want 1", cfg_ready_o);
        end
        step(3);
        rst_n = 1'b1;
        r2 = cyc;
        $display("reset released at cycle %0d", r2);
        clear_logs();
        exp_tick_q.push_back(r2 + 1);
        exp_tick_q.push_back(r2 + 51);
        exp_high_q.push_back(25);
        step(60);
        settle();
        while (exp_tick_q.size() > 0) begin
            e = exp_tick_q.pop_front();
            a = -1;
            if (tick_log1.size() > 0) a = tick_log1.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL rstmid_ch1_tick: got %0d want %0d", a, e);
            end
            a = -1;
            if (tick_log0.size() > 0) a = tick_log0.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL rstmid_ch0_tick: got %0d want %0d", a, e);
            end
        end
        e = exp_high_q.pop_front();
        a = -1;
        if (high_log1.size() > 0) a = high_log1.pop_front();
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL rstmid_ch1_high: got %0d want %0d", a, e);
        end
    endtask

    initial begin
        test_reset();
        test_div_update();
        test_disable_enable();
        test_div_zero_one();
        test_out_of_range();
        test_reset_midperiod();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
